// File: rtl/mempool_tcdm_link_cut.sv
// Elastic pipeline cut for the inter-group TCDM links: one 2-entry FIFO per link and
// direction, so the long group-to-group path is registered without losing throughput.
module mempool_tcdm_link_cut #(
  parameter int unsigned NumTilesPerGroup   = 4,
  parameter int unsigned NumLinks           = NumTilesPerGroup,
  parameter bit          CutReq             = 1'b1,
  parameter bit          CutResp            = 1'b1,
  parameter type         tcdm_slave_req_t   = logic [63:0],
  parameter type         tcdm_master_resp_t = logic [39:0]
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  // Group master side
  input  tcdm_slave_req_t   [NumLinks-1:0]       mst_req_i,
  input  logic              [NumLinks-1:0]       mst_req_valid_i,
  output logic              [NumLinks-1:0]       mst_req_ready_o,
  output tcdm_master_resp_t [NumLinks-1:0]       mst_resp_o,
  output logic              [NumLinks-1:0]       mst_resp_valid_o,
  input  logic              [NumLinks-1:0]       mst_resp_ready_i,
  // Peer slave side
  output tcdm_slave_req_t   [NumLinks-1:0]       slv_req_o,
  output logic              [NumLinks-1:0]       slv_req_valid_o,
  input  logic              [NumLinks-1:0]       slv_req_ready_i,
  input  tcdm_master_resp_t [NumLinks-1:0]       slv_resp_i,
  input  logic              [NumLinks-1:0]       slv_resp_valid_i,
  output logic              [NumLinks-1:0]       slv_resp_ready_o,
  // Status
  output logic              [NumLinks-1:0]       busy_o
);

  logic [NumLinks-1:0] req_busy;
  logic [NumLinks-1:0] resp_busy;

  for (genvar l = 0; l < NumLinks; l++) begin : g_link

    // ---------------------------------------------------------------- request channel
    if (CutReq) begin : g_req_cut
      tcdm_slave_req_t [1:0] slot_q, slot_d;
      logic                  rd_q, rd_d;
      logic                  wr_q, wr_d;
      logic [1:0]            cnt_q, cnt_d;
      logic                  in_ready, out_valid;
      logic                  push, pop;

      // Ready depends on the count register only, never on slv_req_ready_i.
      assign in_ready  = (cnt_q != 2'd2);
      assign out_valid = (cnt_q != 2'd0);
      assign push      = mst_req_valid_i[l] & in_ready;
      assign pop       = out_valid & slv_req_ready_i[l];

      always_comb begin
        slot_d = slot_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (push) begin
          slot_d[wr_q] = mst_req_i[l];
          wr_d         = ~wr_q;
        end
        if (pop) begin
          rd_d = ~rd_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          slot_q <= '0;
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
          cnt_q  <= 2'd0;
        end else begin
          slot_q <= slot_d;
          rd_q   <= rd_d;
          wr_q   <= wr_d;
          cnt_q  <= cnt_d;
        end
      end

      assign mst_req_ready_o[l] = in_ready;
      assign slv_req_valid_o[l] = out_valid;
      assign slv_req_o[l]       = slot_q[rd_q];
      assign req_busy[l]        = out_valid;
    end else begin : g_req_bypass
      assign slv_req_o[l]       = mst_req_i[l];
      assign slv_req_valid_o[l] = mst_req_valid_i[l];
      assign mst_req_ready_o[l] = slv_req_ready_i[l];
      assign req_busy[l]        = 1'b0;
    end

    // --------------------------------------------------------------- response channel
    if (CutResp) begin : g_resp_cut
      tcdm_master_resp_t [1:0] slot_q, slot_d;
      logic                    rd_q, rd_d;
      logic                    wr_q, wr_d;
      logic [1:0]              cnt_q, cnt_d;
      logic                    in_ready, out_valid;
      logic                    push, pop;

      assign in_ready  = (cnt_q != 2'd2);
      assign out_valid = (cnt_q != 2'd0);
      assign push      = slv_resp_valid_i[l] & in_ready;
      assign pop       = out_valid & mst_resp_ready_i[l];

      always_comb begin
        slot_d = slot_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (push) begin
          slot_d[wr_q] = slv_resp_i[l];
          wr_d         = ~wr_q;
        end
        if (pop) begin
          rd_d = ~rd_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          slot_q <= '0;
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
          cnt_q  <= 2'd0;
        end else begin
          slot_q <= slot_d;
          rd_q   <= rd_d;
          wr_q   <= wr_d;
          cnt_q  <= cnt_d;
        end
      end

      assign slv_resp_ready_o[l] = in_ready;
      assign mst_resp_valid_o[l] = out_valid;
      assign mst_resp_o[l]       = slot_q[rd_q];
      assign resp_busy[l]        = out_valid;
    end else begin : g_resp_bypass
      assign mst_resp_o[l]       = slv_resp_i[l];
      assign mst_resp_valid_o[l] = slv_resp_valid_i[l];
      assign slv_resp_ready_o[l] = mst_resp_ready_i[l];
      assign resp_busy[l]        = 1'b0;
    end

  end

  assign busy_o = req_busy | resp_busy;

endmodule

// File: tb/tb_mempool_tcdm_link_cut.sv
// Randomized and directed bench for mempool_tcdm_link_cut: a fully cut instance and a
// request-bypass instance share stimulus and are checked against per-link queue models.
module tb_mempool_tcdm_link_cut;

  localparam int NL = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [NL-1:0][63:0] mst_req_i;
  logic [NL-1:0]       mst_req_valid_i;
  logic [NL-1:0]       mst_resp_ready_i;
  logic [NL-1:0]       slv_req_ready_i;
  logic [NL-1:0][39:0] slv_resp_i;
  logic [NL-1:0]       slv_resp_valid_i;

  logic [NL-1:0]       mst_req_ready_o, nc_mst_req_ready_o;
  logic [NL-1:0][39:0] mst_resp_o, nc_mst_resp_o;
  logic [NL-1:0]       mst_resp_valid_o, nc_mst_resp_valid_o;
  logic [NL-1:0][63:0] slv_req_o, nc_slv_req_o;
  logic [NL-1:0]       slv_req_valid_o, nc_slv_req_valid_o;
  logic [NL-1:0]       slv_resp_ready_o, nc_slv_resp_ready_o;
  logic [NL-1:0]       busy_o, nc_busy_o;

  mempool_tcdm_link_cut #(
    .NumLinks(NL), .CutReq(1'b1), .CutResp(1'b1),
    .tcdm_slave_req_t(logic [63:0]), .tcdm_master_resp_t(logic [39:0])
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mst_req_i(mst_req_i), .mst_req_valid_i(mst_req_valid_i), .mst_req_ready_o(mst_req_ready_o),
    .mst_resp_o(mst_resp_o), .mst_resp_valid_o(mst_resp_valid_o),
    .mst_resp_ready_i(mst_resp_ready_i),
    .slv_req_o(slv_req_o), .slv_req_valid_o(slv_req_valid_o), .slv_req_ready_i(slv_req_ready_i),
    .slv_resp_i(slv_resp_i), .slv_resp_valid_i(slv_resp_valid_i),
    .slv_resp_ready_o(slv_resp_ready_o), .busy_o(busy_o)
  );

  mempool_tcdm_link_cut #(
    .NumLinks(NL), .CutReq(1'b0), .CutResp(1'b1),
    .tcdm_slave_req_t(logic [63:0]), .tcdm_master_resp_t(logic [39:0])
  ) dut_nc (
    .clk_i(clk_i), .rst_i(rst_i),
    .mst_req_i(mst_req_i), .mst_req_valid_i(mst_req_valid_i),
    .mst_req_ready_o(nc_mst_req_ready_o),
    .mst_resp_o(nc_mst_resp_o), .mst_resp_valid_o(nc_mst_resp_valid_o),
    .mst_resp_ready_i(mst_resp_ready_i),
    .slv_req_o(nc_slv_req_o), .slv_req_valid_o(nc_slv_req_valid_o),
    .slv_req_ready_i(slv_req_ready_i),
    .slv_resp_i(slv_resp_i), .slv_resp_valid_i(slv_resp_valid_i),
    .slv_resp_ready_o(nc_slv_resp_ready_o), .busy_o(nc_busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference: each buffered channel is a queue holding at most two items.
  logic [63:0] mreq  [NL][$];
  logic [39:0] mresp [NL][$];
  logic [NL-1:0] req_acc, resp_acc;

  // Compare at the falling edge, then advance the model by one clock edge.
  task automatic tick();
    bit rq_push, rq_pop, rs_push, rs_pop;
    @(negedge clk_i);
    for (int l = 0; l < NL; l++) begin
      check_eq("req_ready", mst_req_ready_o[l], mreq[l].size() < 2);
      check_eq("req_valid", slv_req_valid_o[l], mreq[l].size() != 0);
      if (mreq[l].size() != 0) check_eq("req_data", slv_req_o[l], mreq[l][0]);
      check_eq("resp_ready", slv_resp_ready_o[l], mresp[l].size() < 2);
      check_eq("resp_valid", mst_resp_valid_o[l], mresp[l].size() != 0);
      if (mresp[l].size() != 0) check_eq("resp_data", mst_resp_o[l], mresp[l][0]);
      check_eq("busy", busy_o[l], (mreq[l].size() != 0) || (mresp[l].size() != 0));
      check_eq("nc_req_valid", nc_slv_req_valid_o[l], mst_req_valid_i[l]);
      check_eq("nc_req_data", nc_slv_req_o[l], mst_req_i[l]);
      check_eq("nc_req_ready", nc_mst_req_ready_o[l], slv_req_ready_i[l]);
      check_eq("nc_resp_valid", nc_mst_resp_valid_o[l], mresp[l].size() != 0);
      if (mresp[l].size() != 0) check_eq("nc_resp_data", nc_mst_resp_o[l], mresp[l][0]);
      check_eq("nc_busy", nc_busy_o[l], mresp[l].size() != 0);
    end
    for (int l = 0; l < NL; l++) begin
      rq_push = mst_req_valid_i[l] && (mreq[l].size() < 2);
      rq_pop  = (mreq[l].size() != 0) && slv_req_ready_i[l];
      rs_push = slv_resp_valid_i[l] && (mresp[l].size() < 2);
      rs_pop  = (mresp[l].size() != 0) && mst_resp_ready_i[l];
      if (rq_pop) void'(mreq[l].pop_front());
      if (rq_push) mreq[l].push_back(mst_req_i[l]);
      if (rs_pop) void'(mresp[l].pop_front());
      if (rs_push) mresp[l].push_back(slv_resp_i[l]);
      req_acc[l]  = rq_push;
      resp_acc[l] = rs_push;
    end
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [63:0] A = 64'hA0A0_0000_0000_000A;
  localparam logic [63:0] B = 64'hB0B0_0000_0000_000B;
  localparam logic [63:0] C = 64'hC0C0_0000_0000_000C;
  localparam logic [39:0] RC = 40'hCC_0000_000C;
  localparam logic [39:0] RD = 40'hDD_0000_000D;
  localparam logic [39:0] R1 = 40'h11_1111_1111;
  localparam logic [39:0] R2 = 40'h22_2222_2222;
  localparam logic [63:0] E1 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] E2 = 64'h2222_0000_0000_0002;
  localparam logic [63:0] E3 = 64'h3333_0000_0000_0003;

  int rdy_pct;

  initial begin
    rst_i            = 1'b1;
    mst_req_i        = '0;
    mst_req_valid_i  = '0;
    mst_resp_ready_i = '1;
    slv_req_ready_i  = '1;
    slv_resp_i       = '0;
    slv_resp_valid_i = '0;
    req_acc          = '0;
    resp_acc         = '0;
    repeat (3) @(posedge clk_i);
    #1;
    for (int l = 0; l < NL; l++) begin
      check_eq("rst_req_ready", mst_req_ready_o[l], 1'b1);
      check_eq("rst_req_valid", slv_req_valid_o[l], 1'b0);
      check_eq("rst_resp_valid", mst_resp_valid_o[l], 1'b0);
      check_eq("rst_busy", busy_o[l], 1'b0);
      check_eq("rst_req_data", slv_req_o[l], 64'h0);
    end
    rst_i = 1'b0;
    tick();

    // Back-to-back A,B,C; bypass instance forwards in the same cycle
    mst_req_valid_i[0] = 1'b1; mst_req_i[0] = A;
    #1;
    check_eq("t6_nc_same_cycle", nc_slv_req_o[0], A);
    check_eq("t6_nc_valid", nc_slv_req_valid_o[0], 1'b1);
    tick();
    check_eq("t1_out_a", slv_req_o[0], A);
    mst_req_i[0] = B;
    tick();
    check_eq("t1_out_b", slv_req_o[0], B);
    check_eq("t1_ready", mst_req_ready_o[0], 1'b1);
    mst_req_i[0] = C;
    tick();
    check_eq("t1_out_c", slv_req_o[0], C);
    mst_req_valid_i[0] = 1'b0;
    tick();
    check_eq("t1_drained", slv_req_valid_o[0], 1'b0);

    // Stall: two items fill the buffer, third waits
    slv_req_ready_i[0] = 1'b0;
    mst_req_valid_i[0] = 1'b1; mst_req_i[0] = A;
    tick();
    check_eq("t2_ready_1", mst_req_ready_o[0], 1'b1);
    mst_req_i[0] = B;
    tick();
    check_eq("t2_full", mst_req_ready_o[0], 1'b0);
    mst_req_i[0] = C;
    tick();
    check_eq("t2_still_full", mst_req_ready_o[0], 1'b0);
    check_eq("t2_hold_a", slv_req_o[0], A);
    slv_req_ready_i[0] = 1'b1;
    tick();
    check_eq("t2_out_b", slv_req_o[0], B);
    check_eq("t2_ready_back", mst_req_ready_o[0], 1'b1);
    tick();
    check_eq("t2_out_c", slv_req_o[0], C);
    mst_req_valid_i[0] = 1'b0;
    tick();

    // Response channel: simultaneous push and pop at count 1
    slv_resp_valid_i[0] = 1'b1; slv_resp_i[0] = RC;
    #1;
    check_eq("t6_nc_resp_latency", nc_mst_resp_valid_o[0], 1'b0);
    tick();
    check_eq("t3_out_c", mst_resp_o[0], RC);
    slv_resp_i[0] = RD;
    tick();
    check_eq("t3_out_d", mst_resp_o[0], RD);
    check_eq("t3_busy", busy_o[0], 1'b1);
    check_eq("t6_nc_resp_d", nc_mst_resp_o[0], RD);
    slv_resp_valid_i[0] = 1'b0;
    tick();
    check_eq("t3_idle", busy_o[0], 1'b0);

    // Asynchronous reset with both channels full
    slv_req_ready_i[0] = 1'b0; mst_resp_ready_i[0] = 1'b0;
    mst_req_valid_i[0] = 1'b1; mst_req_i[0] = E1;
    slv_resp_valid_i[0] = 1'b1; slv_resp_i[0] = R1;
    tick();
    mst_req_i[0] = E2; slv_resp_i[0] = R2;
    tick();
    mst_req_valid_i[0] = 1'b0; slv_resp_valid_i[0] = 1'b0;
    check_eq("t5_full", mst_req_ready_o[0], 1'b0);
    #3;
    rst_i = 1'b1;
    #1;
    check_eq("t5_req_valid", slv_req_valid_o[0], 1'b0);
    check_eq("t5_req_ready", mst_req_ready_o[0], 1'b1);
    check_eq("t5_resp_valid", mst_resp_valid_o[0], 1'b0);
    check_eq("t5_resp_ready", slv_resp_ready_o[0], 1'b1);
    check_eq("t5_busy", busy_o[0], 1'b0);
    check_eq("t5_req_data", slv_req_o[0], 64'h0);
    check_eq("t5_resp_data", mst_resp_o[0], 40'h0);
    for (int l = 0; l < NL; l++) begin
      mreq[l].delete();
      mresp[l].delete();
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    slv_req_ready_i[0] = 1'b1; mst_resp_ready_i[0] = 1'b1;
    mst_req_valid_i[0] = 1'b1; mst_req_i[0] = E3;
    tick();
    check_eq("t5_new_push", slv_req_o[0], E3);
    check_eq("t5_new_valid", slv_req_valid_o[0], 1'b1);
    mst_req_valid_i[0] = 1'b0;
    tick();

    // Random traffic; held inputs stay stable until accepted
    for (int cyc = 0; cyc < 10000 && n_fail < 50; cyc++) begin
      case ((cyc / 1000) % 4)
        0:       rdy_pct = 90;
        1:       rdy_pct = 30;
        2:       rdy_pct = 60;
        default: rdy_pct = 100;
      endcase
      for (int l = 0; l < NL; l++) begin
        if (!mst_req_valid_i[l] || req_acc[l]) begin
          mst_req_valid_i[l] = ($urandom_range(0, 3) != 0);
          mst_req_i[l]       = {$urandom, $urandom};
        end
        if (!slv_resp_valid_i[l] || resp_acc[l]) begin
          slv_resp_valid_i[l] = ($urandom_range(0, 3) != 0);
          slv_resp_i[l]       = {8'($urandom), $urandom};
        end
        slv_req_ready_i[l]  = ($urandom_range(0, 99) < rdy_pct);
        mst_resp_ready_i[l] = ($urandom_range(0, 99) < rdy_pct);
      end
      tick();
    end

    mst_req_valid_i  = '0;
    slv_resp_valid_i = '0;
    slv_req_ready_i  = '1;
    mst_resp_ready_i = '1;
    repeat (4) tick();
    for (int l = 0; l < NL; l++) check_eq("final_idle", busy_o[l], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
